// File: rtl/dds_sweep_ctrl.sv
// Stepped-frequency sweep sequencer feeding the dds phase increment and clock enable.
// Optional macro DDS_SWEEP_LOOP_EN: restart the sweep endlessly instead of finishing.
module dds_sweep_ctrl #(
    parameter int unsigned INC_W   = 31,
    parameter int unsigned CNT_W   = 12,
    parameter int unsigned DWELL_W = 16
) (
    input  logic               i_clk,
    input  logic               reset,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic [INC_W-1:0]   i_start_inc,
    input  logic [INC_W-1:0]   i_step_inc,
    input  logic [CNT_W-1:0]   i_num_steps,
    input  logic [DWELL_W-1:0] i_dwell,
    output logic [INC_W-1:0]   o_increment,
    output logic               o_ce,
    output logic               o_busy,
    output logic               o_done,
    output logic [CNT_W-1:0]   o_step_idx
);

    typedef enum logic [1:0] {StIdle, StDwell, StDone} state_e;

    state_e             state_q, state_d;
    logic [INC_W-1:0]   inc_q, inc_d;
    logic [INC_W-1:0]   step_q, step_d;
    logic [CNT_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   num_q, num_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               ce_q, ce_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
`ifdef DDS_SWEEP_LOOP_EN
    logic [INC_W-1:0]   start_q, start_d;
`endif

    logic               start_ok;
    logic [DWELL_W-1:0] dwell_rl;

    assign start_ok = i_start & ~i_abort;
    // Counter reloads with dwell-1 and expires at zero, so a dwell of 0 behaves as 1.
    assign dwell_rl = (i_dwell == '0) ? '0 : i_dwell - DWELL_W'(1);

    always_comb begin
        state_d = state_q;
        inc_d   = inc_q;
        step_d  = step_q;
        idx_d   = idx_q;
        num_d   = num_q;
        cnt_d   = cnt_q;
        dwell_d = dwell_q;
        ce_d    = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
`ifdef DDS_SWEEP_LOOP_EN
        start_d = start_q;
`endif
        case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (start_ok) begin
                    state_d = StDwell;
                    inc_d   = i_start_inc;
                    step_d  = i_step_inc;
                    idx_d   = '0;
                    num_d   = i_num_steps;
                    cnt_d   = dwell_rl;
                    dwell_d = dwell_rl;
                    ce_d    = 1'b1;
                    busy_d  = 1'b1;
`ifdef DDS_SWEEP_LOOP_EN
                    start_d = i_start_inc;
`endif
                end
            end
            StDwell: begin
                if (i_abort) begin
                    state_d = StIdle;
                end else begin
                    ce_d   = 1'b1;
                    busy_d = 1'b1;
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - DWELL_W'(1);
                    end else if (idx_q == num_q) begin
`ifdef DDS_SWEEP_LOOP_EN
                        inc_d  = start_q;
                        idx_d  = '0;
                        cnt_d  = dwell_q;
                        done_d = 1'b1;
`else
                        state_d = StDone;
                        ce_d    = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
`endif
                    end else begin
                        inc_d = inc_q + step_q;
                        idx_d = idx_q + CNT_W'(1);
                        cnt_d = dwell_q;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!reset) begin
            state_q <= StIdle;
            inc_q   <= '0;
            step_q  <= '0;
            idx_q   <= '0;
            num_q   <= '0;
            cnt_q   <= '0;
            dwell_q <= '0;
            ce_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef DDS_SWEEP_LOOP_EN
            start_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            inc_q   <= inc_d;
            step_q  <= step_d;
            idx_q   <= idx_d;
            num_q   <= num_d;
            cnt_q   <= cnt_d;
            dwell_q <= dwell_d;
            ce_q    <= ce_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef DDS_SWEEP_LOOP_EN
            start_q <= start_d;
`endif
        end
    end

    assign o_increment = inc_q;
    assign o_step_idx  = idx_q;
    assign o_ce        = ce_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Scoreboard bench for dds_sweep_ctrl: stimulus queues cycle-stamped expectations,
// a negedge monitor pops and compares them whenever o_ce or o_done is high.
module tb_dds_sweep_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        i_start = 1'b0;
    logic        i_abort = 1'b0;
    logic [30:0] i_start_inc = '0;
    logic [30:0] i_step_inc = '0;
    logic [11:0] i_num_steps = '0;
    logic [15:0] i_dwell = '0;
    logic [30:0] o_increment;
    logic        o_ce;
    logic        o_busy;
    logic        o_done;
    logic [11:0] o_step_idx;

    dds_sweep_ctrl dut (
        .i_clk      (clk),
        .reset      (reset),
        .i_start    (i_start),
        .i_abort    (i_abort),
        .i_start_inc(i_start_inc),
        .i_step_inc (i_step_inc),
        .i_num_steps(i_num_steps),
        .i_dwell    (i_dwell),
        .o_increment(o_increment),
        .o_ce       (o_ce),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_step_idx (o_step_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_done;
        int          cyc;
        logic [30:0] inc;
        logic [11:0] idx;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   errs = 0;
    int   ncnt = 0;   // negedges seen; cycle n contains negedge n

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s at cycle %0d: got %0h, want %0h", name, ncnt, act, exp);
        end
    endtask

    task automatic check_pop(input bit is_done);
        exp_t e;
        if (q.size() == 0) begin
            vectors++;
            errs++;
            $display("FAIL unexpected_%s at cycle %0d: got output, want none",
                     is_done ? "done" : "ce", ncnt);
        end else begin
            e = q.pop_front();
            chk("kind", 32'(is_done), 32'(e.is_done));
            chk("cycle", ncnt, e.cyc);
            if (!is_done) begin
                chk("increment", 32'(o_increment), 32'(e.inc));
                chk("step_idx", 32'(o_step_idx), 32'(e.idx));
            end
        end
    endtask

    always @(negedge clk) begin
        ncnt++;
        while (q.size() > 0 && q[0].cyc < ncnt) begin
            vectors++;
            errs++;
            $display("FAIL missing_%s at cycle %0d: got nothing, want output",
                     q[0].is_done ? "done" : "ce", q[0].cyc);
            void'(q.pop_front());
        end
        chk("busy_vs_ce", 32'(o_busy), 32'(o_ce));
        if (o_done === 1'b1) check_pop(1'b1);
        if (o_ce === 1'b1) check_pop(1'b0);
    end

    // Returns in the drive window of cycle ncnt+1.
    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (ncnt + 1 < c) next_cyc();
    endtask

    task automatic push_steps(input int cyc, input logic [30:0] inc, input logic [11:0] idx,
                              input int n);
        for (int i = 0; i < n; i++) q.push_back('{1'b0, cyc + i, inc, idx});
    endtask

    task automatic push_done(input int cyc);
        q.push_back('{1'b1, cyc, '0, '0});
    endtask

    // Start pulse in the current cycle; base is the first o_ce cycle. Config is then
    // scrambled to show it is only sampled at the latch.
    task automatic drive_start(input logic [30:0] s, input logic [30:0] st,
                               input logic [11:0] n, input logic [15:0] d, output int base);
        i_start_inc = s;
        i_step_inc  = st;
        i_num_steps = n;
        i_dwell     = d;
        i_start     = 1'b1;
        base        = ncnt + 2;
        next_cyc();
        i_start     = 1'b0;
        i_start_inc = 31'h1555;
        i_step_inc  = 31'h3;
        i_num_steps = 12'd7;
        i_dwell     = 16'd9;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_increment"}, 32'(o_increment), 32'h0);
        chk({tag, "_step_idx"}, 32'(o_step_idx), 32'h0);
        chk({tag, "_ce"}, 32'(o_ce), 32'h0);
        chk({tag, "_busy"}, 32'(o_busy), 32'h0);
        chk({tag, "_done"}, 32'(o_done), 32'h0);
    endtask

    int b, b2, b3, b4, b5;

    initial begin
        @(negedge clk);
        @(negedge clk);
        check_zero("reset");
        next_cyc();
        reset = 1'b1;
        next_cyc();
`ifdef DDS_SWEEP_LOOP_EN
        drive_start(31'd100, 31'd10, 12'd3, 16'd4, b);
        for (int l = 0; l < 2; l++) begin
            if (l > 0) push_done(b + 16 * l);
            push_steps(b + 16 * l, 31'd100, 12'd0, 4);
            push_steps(b + 16 * l + 4, 31'd110, 12'd1, 4);
            push_steps(b + 16 * l + 8, 31'd120, 12'd2, 4);
            push_steps(b + 16 * l + 12, 31'd130, 12'd3, 4);
        end
        push_done(b + 32);
        push_steps(b + 32, 31'd100, 12'd0, 2);
        wait_until(b + 33);
        i_abort = 1'b1;
        next_cyc();
        i_abort = 1'b0;
        repeat (6) next_cyc();
`else
        // Basic sweep, with a start request mid-sweep that must be ignored.
        drive_start(31'd100, 31'd10, 12'd3, 16'd4, b);
        push_steps(b, 31'd100, 12'd0, 4);
        push_steps(b + 4, 31'd110, 12'd1, 4);
        push_steps(b + 8, 31'd120, 12'd2, 4);
        push_steps(b + 12, 31'd130, 12'd3, 4);
        push_done(b + 16);
        wait_until(b + 6);
        i_start = 1'b1;
        i_start_inc = 31'd999;
        next_cyc();
        i_start = 1'b0;

        // Start in the done cycle, zero dwell and zero steps.
        wait_until(b + 16);
        drive_start(31'd42, 31'd7, 12'd0, 16'd0, b2);
        push_steps(b2, 31'd42, 12'd0, 1);
        push_done(b2 + 1);

        // Negative step wraps modulo 2^31.
        wait_until(b2 + 3);
        drive_start(31'd5, 31'h7FFFFFF6, 12'd1, 16'd2, b3);
        push_steps(b3, 31'd5, 12'd0, 2);
        push_steps(b3 + 2, 31'h7FFFFFFB, 12'd1, 2);
        push_done(b3 + 4);

        // Start and abort together in idle: nothing happens.
        wait_until(b3 + 6);
        i_start = 1'b1;
        i_abort = 1'b1;
        next_cyc();
        i_start = 1'b0;
        i_abort = 1'b0;

        // Abort at dwell cycle 2 of step 1: no done.
        repeat (3) next_cyc();
        drive_start(31'd100, 31'd10, 12'd3, 16'd4, b4);
        push_steps(b4, 31'd100, 12'd0, 4);
        push_steps(b4 + 4, 31'd110, 12'd1, 2);
        wait_until(b4 + 5);
        i_abort = 1'b1;
        next_cyc();
        i_abort = 1'b0;

        // Reset mid-sweep clears every output the next cycle.
        repeat (4) next_cyc();
        drive_start(31'd200, 31'h7FFFFFFF, 12'd2, 16'd3, b5);
        push_steps(b5, 31'd200, 12'd0, 3);
        push_steps(b5 + 3, 31'd199, 12'd1, 1);
        wait_until(b5 + 3);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_zero("midreset");
        next_cyc();
        reset = 1'b1;
        repeat (8) next_cyc();
`endif
        if (q.size() != 0) begin
            vectors++;
            errs++;
            $display("FAIL leftover: got %0d pending expectations, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
